// File: rtl/grn_pkg.sv
// Shared constants, LUT container type and LUT evaluation helper for GRN network nodes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package grn_pkg;

    localparam int GRN_SKIP_W     = 4;
    localparam int GRN_STAB_W     = 8;
    localparam int GRN_MAX_INPUTS = 6;

    // Wide enough for the largest supported table (2**6 entries).
    typedef logic [63:0] grn_lut_t;

    // Library node tables.
    // STAT1: ~in[1] & (in[0] | in[2] | in[3])
    localparam logic [15:0] GRN_LUT_STAT1 = 16'h3332;

    function automatic logic lut_eval(input grn_lut_t lut, input logic [5:0] idx);
        return lut[idx];
    endfunction

endpackage

// File: rtl/grn_node_lut_if.sv
// Node control/observation bundle: network re-init, per-copy start strobes and regulator bits
// in; per-copy state, change pulse and stability flag out.
// Latency: n/a. Backpressure: none, strobes are accepted unconditionally.
interface grn_node_lut_if #(
    parameter int N_COPIES = 2,
    parameter int N_INPUTS = 4
);
    logic                         reset_nos;
    logic                         init_state;
    logic [N_COPIES-1:0]          start;
    logic [N_COPIES*N_INPUTS-1:0] in_bits;
    logic [N_COPIES-1:0]          s;
    logic [N_COPIES-1:0]          changed;
    logic [N_COPIES-1:0]          stable;

    modport master (
        output reset_nos, init_state, start, in_bits,
        input  s, changed, stable
    );

    modport slave (
        input  reset_nos, init_state, start, in_bits,
        output s, changed, stable
    );
endinterface

// File: rtl/grn_node_copy.sv
// One simulation copy of a LUT node: state bit, skip divider, stability counter.
// Latency: 1 cycle from start strobe to updated o_s/o_changed/o_stable.
// Backpressure: none; every start is either an evaluation or a skip.
// Ports: clk/rst; i_reset_nos, i_init_state (network re-init); i_start, i_in_bits (update);
//        o_s (state), o_changed (1-cycle pulse on changing eval), o_stable (held long enough).
module grn_node_copy
    import grn_pkg::*;
#(
    parameter int                      N_INPUTS      = 4,
    parameter logic [2**N_INPUTS-1:0]  LUT           = GRN_LUT_STAT1,
    parameter int                      SKIP_W        = GRN_SKIP_W,
    parameter logic [SKIP_W-1:0]       SKIP          = '0,
    parameter int                      STAB_W        = GRN_STAB_W,
    parameter int                      STABLE_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_reset_nos,
    input  logic                i_init_state,
    input  logic                i_start,
    input  logic [N_INPUTS-1:0] i_in_bits,
    output logic                o_s,
    output logic                o_changed,
    output logic                o_stable
);

    logic              r_s;
    logic [SKIP_W-1:0] r_cnt;
    logic [STAB_W-1:0] r_stab;
    logic              r_changed;
    logic              r_stable;

    logic              w_lut_out;
    logic              w_s_nxt;
    logic [SKIP_W-1:0] w_cnt_nxt;
    logic [STAB_W-1:0] w_stab_nxt;
    logic              w_changed_nxt;
    logic              w_stable_nxt;

    assign w_lut_out = lut_eval(grn_lut_t'(LUT), 6'(i_in_bits));

    always_comb begin
        w_s_nxt       = r_s;
        w_cnt_nxt     = r_cnt;
        w_stab_nxt    = r_stab;
        w_changed_nxt = 1'b0;   // changed is a pulse: cleared unless this edge is a changing eval

        if (i_reset_nos) begin
            // Re-init wins over start; zeroed skip count makes the next start evaluate.
            w_s_nxt    = i_init_state;
            w_cnt_nxt  = '0;
            w_stab_nxt = '0;
        end else if (i_start) begin
            if (r_cnt == '0) begin
                w_s_nxt   = w_lut_out;
                w_cnt_nxt = SKIP;
                if (w_lut_out == r_s) begin
                    // Saturate so a long-settled copy never wraps back to unstable.
                    if (r_stab != '1) begin
                        w_stab_nxt = r_stab + 1'b1;
                    end
                end else begin
                    w_stab_nxt    = '0;
                    w_changed_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    // Registered from the post-update count so stable rises on the threshold-reaching edge.
    assign w_stable_nxt = (w_stab_nxt >= STAB_W'(STABLE_THRESH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= 1'b0;
            r_cnt     <= '0;
            r_stab    <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b0;
        end else begin
            r_s       <= w_s_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stab    <= w_stab_nxt;
            r_changed <= w_changed_nxt;
            r_stable  <= w_stable_nxt;
        end
    end

    assign o_s       = r_s;
    assign o_changed = r_changed;
    assign o_stable  = r_stable;

endmodule

// File: rtl/grn_node_lut.sv
// Parametrised Boolean-network node: N_COPIES independent LUT-evaluated state copies.
// Latency: 1 cycle from start[c] to s/changed/stable of copy c.
// Backpressure: none; start strobes are always accepted.
// Ports: clk, rst (sync, active-high); bus (slave modport: reset_nos, init_state, start,
//        in_bits in; s, changed, stable out).
module grn_node_lut
    import grn_pkg::*;
#(
    parameter int                           N_COPIES      = 2,
    parameter int                           N_INPUTS      = 4,
    parameter logic [2**N_INPUTS-1:0]       LUT           = GRN_LUT_STAT1,
    parameter int                           SKIP_W        = GRN_SKIP_W,
    parameter logic [N_COPIES*SKIP_W-1:0]   SKIP_VEC      = {4'd0, 4'd1},
    parameter int                           STAB_W        = GRN_STAB_W,
    parameter int                           STABLE_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    grn_node_lut_if.slave bus
);

    logic [N_COPIES-1:0] w_s;
    logic [N_COPIES-1:0] w_changed;
    logic [N_COPIES-1:0] w_stable;

    for (genvar c = 0; c < N_COPIES; c++) begin : g_copy
        grn_node_copy #(
            .N_INPUTS      (N_INPUTS),
            .LUT           (LUT),
            .SKIP_W        (SKIP_W),
            .SKIP          (SKIP_VEC[c*SKIP_W +: SKIP_W]),
            .STAB_W        (STAB_W),
            .STABLE_THRESH (STABLE_THRESH)
        ) u_copy (
            .clk          (clk),
            .rst          (rst),
            .i_reset_nos  (bus.reset_nos),
            .i_init_state (bus.init_state),
            .i_start      (bus.start[c]),
            .i_in_bits    (bus.in_bits[c*N_INPUTS +: N_INPUTS]),
            .o_s          (w_s[c]),
            .o_changed    (w_changed[c]),
            .o_stable     (w_stable[c])
        );
    end

    assign bus.s       = w_s;
    assign bus.changed = w_changed;
    assign bus.stable  = w_stable;

endmodule

// File: tb/tb_grn_node_lut.sv
// Testbench for grn_node_lut with default parameters (2 copies, STAT1 LUT, skips {1,0}).
// Expected outputs come from a behavioural model pushed into a scoreboard per driven cycle,
// plus directed constant checks at the scenario points of interest.
module tb_grn_node_lut;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grn_node_lut_if #(.N_COPIES(2), .N_INPUTS(4)) bus ();

    grn_node_lut dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] s;
        logic [1:0] chg;
        logic [1:0] stb;
    } exp_t;

    exp_t q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic [1:0] m_s, m_chg, m_stb;
    int         m_cnt [2];
    int         m_stab[2];
    int         skip_c[2] = '{1, 0};

    // Node function written from its Boolean form, independent of the LUT constant.
    function automatic logic node_f(input logic [3:0] in);
        return ~in[1] & (in[0] | in[2] | in[3]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic rn, input logic init,
                         input logic [1:0] st, input logic [3:0] in0, input logic [3:0] in1);
        logic nxt;
        logic [3:0] inc;
        if (r) begin
            m_s = '0; m_chg = '0; m_stb = '0;
            for (int c = 0; c < 2; c++) begin m_cnt[c] = 0; m_stab[c] = 0; end
        end else if (rn) begin
            m_s = {init, init}; m_chg = '0; m_stb = '0;
            for (int c = 0; c < 2; c++) begin m_cnt[c] = 0; m_stab[c] = 0; end
        end else begin
            for (int c = 0; c < 2; c++) begin
                inc = (c == 0) ? in0 : in1;
                m_chg[c] = 1'b0;
                if (st[c]) begin
                    if (m_cnt[c] == 0) begin
                        nxt = node_f(inc);
                        if (nxt == m_s[c]) begin
                            if (m_stab[c] < 255) m_stab[c]++;
                        end else begin
                            m_stab[c] = 0;
                            m_chg[c]  = 1'b1;
                        end
                        m_s[c]   = nxt;
                        m_cnt[c] = skip_c[c];
                    end else begin
                        m_cnt[c]--;
                    end
                end
                m_stb[c] = (m_stab[c] >= 4);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic rn, input logic init,
                        input logic [1:0] st, input logic [3:0] in0, input logic [3:0] in1);
        exp_t e;
        rst            = r;
        bus.reset_nos  = rn;
        bus.init_state = init;
        bus.start      = st;
        bus.in_bits    = {in1, in0};
        model(r, rn, init, st, in0, in1);
        q.push_back('{s: m_s, chg: m_chg, stb: m_stb});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".s"},       32'(bus.s),       32'(e.s));
        chk({tag, ".changed"}, 32'(bus.changed), 32'(e.chg));
        chk({tag, ".stable"},  32'(bus.stable),  32'(e.stb));
    endtask

    initial begin
        rst = 1'b1;
        bus.reset_nos = 1'b0; bus.init_state = 1'b0; bus.start = '0; bus.in_bits = '0;

        // Reset for two cycles
        step("rst0", 1, 0, 0, 2'b00, 4'h0, 4'h0);
        step("rst1", 1, 0, 0, 2'b00, 4'h0, 4'h0);
        chk("rst_s", 32'(bus.s), 32'h0);
        chk("rst_stable", 32'(bus.stable), 32'h0);

        // Network re-init to 1
        step("nos1", 0, 1, 1, 2'b00, 4'h0, 4'h0);
        chk("nos_s", 32'(bus.s), 32'h3);

        // Copy1 basic LUT evaluation
        step("c1_0001", 0, 0, 0, 2'b10, 4'h0, 4'b0001);
        chk("c1_s_one", 32'(bus.s[1]), 32'h1);
        step("c1_0011", 0, 0, 0, 2'b10, 4'h0, 4'b0011);
        chk("c1_s_zero", 32'(bus.s[1]), 32'h0);
        chk("c1_chg_pulse", 32'(bus.changed[1]), 32'h1);
        step("c1_idle", 0, 0, 0, 2'b00, 4'h0, 4'b0011);
        chk("c1_chg_clear", 32'(bus.changed[1]), 32'h0);

        // Copy0 skip=1: LUT results 0,1,1,0 on starts 1..4; only 1 and 3 evaluate
        step("sk1", 0, 0, 0, 2'b01, 4'b0010, 4'h0);
        chk("sk1_s", 32'(bus.s[0]), 32'h0);
        step("sk2", 0, 0, 0, 2'b01, 4'b0001, 4'h0);
        chk("sk2_s", 32'(bus.s[0]), 32'h0);
        chk("sk2_chg", 32'(bus.changed[0]), 32'h0);
        step("sk3", 0, 0, 0, 2'b01, 4'b0001, 4'h0);
        chk("sk3_s", 32'(bus.s[0]), 32'h1);
        chk("sk3_chg", 32'(bus.changed[0]), 32'h1);
        step("sk4", 0, 0, 0, 2'b01, 4'b0010, 4'h0);
        chk("sk4_s", 32'(bus.s[0]), 32'h1);

        // Stability on copy1: four no-change evaluations
        for (int i = 0; i < 4; i++) begin
            step("stab", 0, 0, 0, 2'b10, 4'h0, 4'b0011);
            if (i == 2) chk("stab_3rd", 32'(bus.stable[1]), 32'h0);
        end
        chk("stab_4th", 32'(bus.stable[1]), 32'h1);
        step("stab_chg", 0, 0, 0, 2'b10, 4'h0, 4'b0001);
        chk("stab_drop", 32'(bus.stable[1]), 32'h0);
        chk("stab_chg_pulse", 32'(bus.changed[1]), 32'h1);

        // Saturation: long no-change run must not wrap
        for (int i = 0; i < 300; i++) step("sat", 0, 0, 0, 2'b10, 4'h0, 4'b0001);
        chk("sat_stable", 32'(bus.stable[1]), 32'h1);

        // reset_nos with simultaneous starts; copy0 left mid-skip first
        step("pre_nos", 0, 0, 0, 2'b01, 4'b0010, 4'h0);
        step("nos_st", 0, 1, 0, 2'b11, 4'b0001, 4'b0001);
        chk("nos_st_s", 32'(bus.s), 32'h0);
        chk("nos_st_chg", 32'(bus.changed), 32'h0);
        step("post_nos", 0, 0, 0, 2'b01, 4'b0001, 4'h0);
        chk("post_nos_s0", 32'(bus.s[0]), 32'h1);

        // Mid-operation rst discards stability progress
        step("pre_r1", 0, 0, 0, 2'b10, 4'h0, 4'b0011);
        step("pre_r2", 0, 0, 0, 2'b10, 4'h0, 4'b0011);
        step("mid_rst", 1, 0, 0, 2'b11, 4'h1, 4'b0011);
        chk("mid_rst_s", 32'(bus.s), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step("post_rst", 0, 0, 0, 2'b10, 4'h0, 4'b0011);
            if (i == 2) chk("post_rst_3rd", 32'(bus.stable[1]), 32'h0);
        end
        chk("post_rst_4th", 32'(bus.stable[1]), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step("rnd",
                 logic'($urandom_range(0, 49) == 0),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        chk("sb_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/grn_node_lut.md
# grn_node_lut

Parametrised Boolean-network node for the GNR accelerator fabric. Holds one state bit per simulation copy and evaluates a truth-table (LUT) update function over `N_INPUTS` regulator bits on each copy's start strobe. A per-copy skip divider sets the update rate, and a per-copy stability counter flags when a copy's state has held for `STABLE_THRESH` consecutive evaluations. It replaces hand-written fixed-function, fixed-two-copy node modules in generated networks.

## Interface
Parameters:
- `N_COPIES`, 2: number of independent state copies.
- `N_INPUTS`, 4: regulator inputs per copy (1..6).
- `LUT`, 16'h3332 (width 2**N_INPUTS): next-state truth table. Bit `i` is the next state when the copy's input vector equals `i`. The default is `~in[1] & (in[0]|in[2]|in[3])`.
- `SKIP_W`, 4: width of each skip field.
- `SKIP_VEC`, {4'd0,4'd1} (width N_COPIES*SKIP_W): skip count for copy c at `[c*SKIP_W +: SKIP_W]`. Default: copy0 skips 1, copy1 skips 0.
- `STAB_W`, 8: stability counter width.
- `STABLE_THRESH`, 4: evaluations without change needed to assert `stable` (1..2**STAB_W-1).

Ports:
- `clk` in 1: clock. Reset `rst` is synchronous, active-high; clock is `clk`.
- `rst` in 1: synchronous active-high reset.
- `reset_nos` in 1: network re-initialise, applied to all copies.
- `init_state` in 1: state loaded on `reset_nos`.
- `start` in N_COPIES: per-copy update strobe.
- `in_bits` in N_COPIES*N_INPUTS: copy c inputs at `[c*N_INPUTS +: N_INPUTS]`.
- `s` out N_COPIES: registered node state per copy.
- `changed` out N_COPIES: one-cycle pulse; the last evaluation altered the state.
- `stable` out N_COPIES: registered; stability count >= `STABLE_THRESH`.

## Operation
- Each copy c holds:
  - state `s[c]`
  - skip counter `cnt_c` (SKIP_W bits)
  - stability counter `stab_c` (STAB_W bits)
- Priority per edge: `rst` > `reset_nos` > `start[c]`.
- `rst` sets `s`=0, `cnt_c`=0, `stab_c`=0, `changed`=0, `stable`=0.
- `reset_nos` sets `s[c]`=`init_state`, `cnt_c`=0, `stab_c`=0, `changed`=0. The first `start` after it always evaluates.
- `start[c]` with `cnt_c`==0 is an evaluation:
  - `nxt` = `LUT[in_bits slice c]`
  - `s[c]` <= `nxt`
  - `cnt_c` <= `SKIP_VEC[c]`
  - if `nxt`==`s[c]`: `stab_c` increments, saturating at all-ones.
  - otherwise: `stab_c` <= 0 and `changed[c]` <= 1.
- `start[c]` with `cnt_c`!=0 is a skip: `cnt_c` decrements. `s`, `stab_c` and `changed` are unchanged, except that `changed` clears.
- No `start[c]`: copy holds and `changed[c]` clears.
- `stable[c]` is registered and computed from the updated `stab_c`, i.e. it asserts on the same edge that `stab_c` reaches the threshold.
- Copies are fully independent. Simultaneous `start` on any subset evaluates each copy in the same cycle.
- `SKIP_VEC` field = 0 gives an evaluation on every start. Field = k gives one evaluation per k+1 starts.

## Timing
- Evaluation latency 1: `s`, `changed` and `stable` reflect an evaluation strobed at edge n from edge n onward, visible in cycle n+1.
- `in_bits` is sampled on the same edge as `start`. There is no input registering.
- `changed` is high for exactly one cycle per changing evaluation. Back-to-back changing evaluations hold it high continuously.
- `reset_nos` asserted together with `start` means the start is ignored.
- `rst` asserted mid-skip or mid-stability-count discards all progress.
- Stability-counter saturation: `stable` remains 1 and there is no wrap-around.

## Structure
- Package `grn_pkg`:
  - `GRN_SKIP_W`, `GRN_STAB_W` default constants.
  - `grn_lut_t` helper function `lut_eval(lut, idx)`.
  - Default LUT constants for library nodes (STAT1 = 16'h3332).
- Sub-module `grn_node_copy`: one copy's state, skip counter, stability counter, `changed` and `stable`. The top instantiates `N_COPIES` of them via generate, slicing `in_bits` and `SKIP_VEC`.

## Test plan
- Reset: `rst`=1 for 2 cycles -> `s`=0, `changed`=0, `stable`=0. `reset_nos` with `init_state`=1 -> `s`=2'b11.
- Default LUT, copy1 with `in`=4'b0001 -> `s[1]`=1. With `in`=4'b0011 -> `s[1]`=0 and a `changed[1]` pulse.
- Copy0 skip=1: 4 consecutive `start[0]` with the input toggling the LUT result -> only starts 1 and 3 update `s[0]`. Starts 2 and 4 leave it and give no `changed`.
- Stability: hold inputs constant, 4 evaluations with no change -> `stable` rises on the 4th. A subsequent changing evaluation -> `stable`=0 and `changed`=1.
- Simultaneous `reset_nos`+`start`=2'b11 -> both copies load `init_state` and do not evaluate. The next `start[0]` evaluates even though copy0 skip=1.
- Mid-operation `rst` after 2 stable evaluations -> `stab` cleared, and it takes 4 fresh no-change evaluations for `stable` to assert.
